counter: RTL and testbench
==========================

COUNTER -- requirements
Module: counter

Interface
REQ-001 SHALL have parameter BW, default 7: width of counter_val_o.
REQ-002 SHALL have parameter MAX_VAL, default 99: upper count limit; 2^BW > MAX_VAL is required.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port up_i, input, 1 bit: count-up event, asynchronous to clk_i; each rising edge is one event.
REQ-006 SHALL have port down_i, input, 1 bit: count-down event, asynchronous to clk_i; each rising edge is one event.
REQ-007 SHALL have port counter_val_o, output, BW bits: current count, unsigned, driven directly from a register.

Function
REQ-008 SHALL pass up_i and down_i each through a two-flop synchroniser clocked by clk_i before any use.
REQ-009 SHALL detect a rising edge per input as synchronised-stage high while a one-cycle history register is low.
REQ-010 SHALL count each high pulse exactly once, regardless of pulse length.
REQ-011 SHALL guarantee detection of pulses whose high and low phases each last at least 2 clk_i cycles.
REQ-012 SHALL update counter_val_o on the 3rd rising clk_i edge, counting the first edge that samples the input high as edge 1.
REQ-013 SHALL increment counter_val_o by 1 on a detected up event when counter_val_o < MAX_VAL.
REQ-014 SHALL hold counter_val_o at MAX_VAL on an up event when already at MAX_VAL; no wrap to 0.
REQ-015 SHALL decrement counter_val_o by 1 on a detected down event when counter_val_o > 0.
REQ-016 SHALL hold counter_val_o at 0 on a down event when already at 0; no wrap to MAX_VAL.
REQ-017 SHALL leave counter_val_o unchanged when up and down events are detected in the same clk_i cycle.
REQ-018 SHALL never present a value greater than MAX_VAL on counter_val_o.
REQ-019 SHALL hold counter_val_o unchanged in every cycle without a detected event.

Reset
REQ-020 SHALL set counter_val_o to 0 on every rising clk_i edge where rst_i = 1.
REQ-021 SHALL give rst_i priority over any event detected in the same cycle.
REQ-022 SHALL clear both synchroniser stages to 0 while rst_i = 1.
REQ-023 SHALL load each history register from its synchronised stage while rst_i = 1.
REQ-024 SHALL NOT count an input level that is already high when rst_i deasserts; counting resumes on that input's next rising edge.
REQ-025 SHALL allow reset assertion at any time, including mid-count, with the same result as REQ-020 to REQ-024.

Verification
REQ-026 SHALL cover reset: rst_i = 1 for 10 cycles while up_i and down_i toggle -> counter_val_o = 0 throughout and on the first edge after release.
REQ-027 SHALL cover count-up: from 0, 5 up_i pulses of 4 cycles high / 4 cycles low -> counter_val_o steps 1 to 5, each step 3 edges after the pulse rise.
REQ-028 SHALL cover upper saturation: from 0, 120 up_i pulses -> counter_val_o reaches 99 and stays 99.
REQ-029 SHALL cover count-down and lower saturation: from 99, 5 down_i pulses -> 94; then 110 more down_i pulses -> 0 and stays 0.
REQ-030 SHALL cover simultaneous and long-pulse events: at 50, up_i and down_i rise in the same cycle -> stays 50; then up_i held high 100 cycles -> exactly 51.
REQ-031 SHALL cover mid-operation reset: at 37, rst_i = 1 for 1 cycle while up_i is held high -> 0 on the next edge, and still 0 after release until up_i falls and rises again, then 1.

Source files
------------

// File: rtl/counter.sv
// Saturating up/down event counter.
// Async up/down edges are synchronised, edge-detected and counted once.
module counter #(
  parameter int BW      = 7,
  parameter int MAX_VAL = 99
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          up_i,
  input  logic          down_i,
  output logic [BW-1:0] counter_val_o
);

  localparam logic [BW-1:0] TOP = BW'(MAX_VAL);

  // bit 0 tracks up_i, bit 1 tracks down_i
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] hist;
  logic [1:0] armed;
  logic       live;
  logic [1:0] ev;

  // live marks s1 as holding a real post-reset sample;
  // armed needs such a low sample, so a level high at release is ignored
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1    <= '0;
      s2    <= '0;
      armed <= '0;
      live  <= 1'b0;
    end else begin
      s1    <= {down_i, up_i};
      s2    <= s1;
      armed <= armed | ({2{live}} & ~s1);
      live  <= 1'b1;
    end
    hist <= s2;
  end

  assign ev = s2 & ~hist & armed;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      counter_val_o <= '0;
    end else begin
      unique case (ev)
        2'b01: begin
          if (counter_val_o < TOP)
            counter_val_o <= counter_val_o + 1'b1;
        end
        2'b10: begin
          if (counter_val_o != '0)
            counter_val_o <= counter_val_o - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_counter.sv
// Bench for counter: vector table, corner sequences
// and random stimulus against an edge-level model.
module tb_counter;

  localparam int BW   = 7;
  localparam int MAXV = 99;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          up  = 1'b0;
  logic          dn  = 1'b0;
  logic [BW-1:0] val;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  int       exp_val = 0;
  logic [3:0] rh = 4'hF;
  logic [3:0] uh = 4'h0;
  logic [3:0] dh = 4'h0;

  counter #(.BW(BW), .MAX_VAL(MAXV)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .up_i          (up),
    .down_i        (dn),
    .counter_val_o (val)
  );

  always #5 clk = ~clk;

  // A rise between two consecutive out-of-reset samples is applied
  // two edges later, provided no reset hits those edges.
  always @(posedge clk) begin : model
    logic [3:0] r, u, d;
    bit ue, de;
    r  = {rh[2:0], rst};
    u  = {uh[2:0], up};
    d  = {dh[2:0], dn};
    ue = (r == 4'b0) && u[2] && !u[3];
    de = (r == 4'b0) && d[2] && !d[3];
    if (rst)
      exp_val <= 0;
    else if (ue && !de && exp_val < MAXV)
      exp_val <= exp_val + 1;
    else if (de && !ue && exp_val > 0)
      exp_val <= exp_val - 1;
    rh <= r;
    uh <= u;
    dh <= d;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model", int'(val), exp_val);
      checks++;
      if (int'(val) > MAXV) begin
        errors++;
        $display("FAIL range: got %0d above %0d", val, MAXV);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit u, input bit d,
                       input int hi, input int lo);
    up = u;
    dn = d;
    tick(hi);
    up = 1'b0;
    dn = 1'b0;
    tick(lo);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
  endtask

  typedef struct {
    string name;
    bit    do_rst;
    int    n_up;
    int    n_dn;
    int    hi;
    int    lo;
    int    exp;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{"up5",     1'b1,   5,   0, 4, 4,  5};
    tbl[1] = '{"up_sat",  1'b1, 120,   0, 2, 2, 99};
    tbl[2] = '{"dn5",     1'b0,   0,   5, 3, 3, 94};
    tbl[3] = '{"dn_sat",  1'b0,   0, 110, 2, 3,  0};
    tbl[4] = '{"up50",    1'b0,  50,   0, 2, 2, 50};
    tbl[5] = '{"dn13",    1'b0,   0,  13, 2, 2, 37};
    tbl[6] = '{"up62",    1'b0,  62,   0, 3, 2, 99};
    tbl[7] = '{"dn99",    1'b0,   0,  99, 2, 2,  0};
    tbl[8] = '{"long_hi", 1'b0,   1,   0, 10, 2, 1};

    tick(2);
    chk_en = 1'b1;

    // reset held while inputs toggle
    for (int i = 0; i < 10; i++) begin
      up = i[0];
      dn = ~i[0];
      tick(1);
      check("rst_hold", int'(val), 0);
    end
    rst = 1'b0;
    up  = 1'b0;
    dn  = 1'b0;
    tick(1);
    check("rst_release", int'(val), 0);
    tick(4);

    // update lands on the third edge after the rise is sampled
    up = 1'b1;
    tick(1);
    check("step_e1", int'(val), 0);
    tick(1);
    check("step_e2", int'(val), 0);
    tick(1);
    check("step_e3", int'(val), 1);
    tick(3);
    up = 1'b0;
    tick(4);

    foreach (tbl[i]) begin
      if (tbl[i].do_rst)
        do_reset();
      for (int k = 0; k < tbl[i].n_up; k++)
        pulse(1'b1, 1'b0, tbl[i].hi, tbl[i].lo);
      for (int k = 0; k < tbl[i].n_dn; k++)
        pulse(1'b0, 1'b1, tbl[i].hi, tbl[i].lo);
      tick(4);
      check(tbl[i].name, int'(val), tbl[i].exp);
    end

    // simultaneous events and a long pulse
    do_reset();
    for (int k = 0; k < 50; k++)
      pulse(1'b1, 1'b0, 2, 2);
    tick(3);
    check("at50", int'(val), 50);
    pulse(1'b1, 1'b1, 4, 4);
    tick(3);
    check("simul", int'(val), 50);
    up = 1'b1;
    tick(100);
    up = 1'b0;
    tick(4);
    check("long", int'(val), 51);

    // reset mid-count with up held high
    for (int k = 0; k < 14; k++)
      pulse(1'b0, 1'b1, 2, 2);
    tick(3);
    check("at37", int'(val), 37);
    up = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(1);
    check("mid_rst", int'(val), 0);
    rst = 1'b0;
    tick(20);
    check("held_hi", int'(val), 0);
    up = 1'b0;
    tick(4);
    up = 1'b1;
    tick(4);
    check("re_rise", int'(val), 1);
    up = 1'b0;
    tick(4);

    // random traffic, mostly upward then mostly downward
    for (int i = 0; i < 3000; i++) begin
      if (i < 1500) begin
        up = ($urandom % 3) != 0;
        dn = ($urandom % 4) == 0;
      end else begin
        up = ($urandom % 4) == 0;
        dn = ($urandom % 3) != 0;
      end
      rst = ($urandom % 200) == 0;
      tick(1);
    end
    rst = 1'b0;
    up  = 1'b0;
    dn  = 1'b0;
    tick(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
